if_id_queue: RTL and testbench
==============================

Name: if_id_queue

Overview:
- Registered instruction buffer between the fetch stage and decode.
- Captures fetch's {instruction, incPC, err, branchInst} bundle into a small FIFO and presents the head entry to decode with a valid/ready handshake.
- Decouples decode stalls from fetch.
- Supplies NOPs on flush and on empty.
- Stops accepting after a HALT until flushed.

Parameters:
- DEPTH, 2, number of entries; legal values 2 or 4 (power of two).
- NOP_INSTR, 16'h0800, encoding driven to decode when no valid entry.
- HALT_OPC, 5'b00000, opcode field [15:11] identifying HALT.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-low reset (sampled on clk rising edge; 0 = reset).
- f_valid  in  1  fetch presents a valid bundle this cycle.
- f_ready  out  1  queue can accept a bundle this cycle.
- f_instr  in  16  fetched instruction.
- f_incPC  in  16  PC+2 of that instruction.
- f_err  in  1  fetch error flag.
- f_branch  in  1  fetch-side branch indication.
- flush  in  1  discard all entries (branch mispredict / redirect).
- d_valid  out  1  head entry valid.
- d_ready  in  1  decode consumes head this cycle.
- d_instr  out  16  head instruction, or NOP_INSTR when d_valid=0.
- d_incPC  out  16  head incPC, or 0 when d_valid=0.
- d_err  out  1  head err, or 0 when d_valid=0.
- d_branch  out  1  head branch flag, or 0 when d_valid=0.
- halted  out  1  HALT enqueued; intake closed.

Behaviour:
- Reset (rst=0 at edge):
  - count=0, wr_ptr=rd_ptr=0, state=RUN.
  - Outputs: d_valid=0, d_instr=NOP_INSTR, d_incPC=0, d_err=0, d_branch=0, halted=0, f_ready=1.
  - Storage contents don't-care.
- push = f_valid & f_ready; pop = d_valid & d_ready.
- f_ready = (count != DEPTH) & (state==RUN).
  - Registered-state only; no combinational path from d_ready.
- d_valid = (count != 0). Head fields come from storage at rd_ptr, muxed to NOP/zeros when count=0.
- Latency: a bundle pushed at edge N is visible to decode after edge N; minimum 1 cycle. No empty bypass.
- Simultaneous push and pop:
  - Legal whenever f_ready=1; count unchanged, both pointers advance.
  - When full, f_ready=0, so no push occurs even if pop occurs.
- Pointers are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- State machine:
  - RUN -> HALTED when push with f_instr[15:11]==HALT_OPC.
  - HALTED -> RUN on flush.
  - halted = (state==HALTED).
  - In HALTED, queued entries (including the HALT) still drain to decode.
- Flush (flush=1, rst=1):
  - At the edge: count=0, pointers=0, state=RUN.
  - Any same-cycle push or pop is ignored; flush has priority.
  - Outputs show NOP/invalid the following cycle.
- Reset has priority over flush. Reset mid-operation discards all entries identically to the reset state.
- f_err entries are queued like any other entry; no special handling.

Decomposition:
- Shared package:
  - NOP_INSTR and HALT_OPC constants.
  - Packed entry typedef if_id_entry_t {instr[15:0], incPC[15:0], err, branch} (34 bits).
- One sub-module: if_id_store.
  - DEPTH x 34 register array.
  - Write port (wr_en, wr_ptr, data), async read at rd_ptr.
- Control (count, pointers, state, muxing) stays in if_id_queue.

Test Plan:
- Reset: hold rst=0 two cycles with f_valid=1 -> d_valid=0, d_instr=16'h0800, f_ready=1, halted=0 after release.
- Fill/drain, DEPTH=2, d_ready=0:
  - Push 16'hA001/incPC 16'h0002, then 16'hA002/16'h0004 -> f_ready=0 after 2nd edge.
  - Raise d_ready -> decode sees A001 then A002 in order, then NOP with d_valid=0.
- Streaming: f_valid=d_ready=1 every cycle for 8 instructions -> each appears exactly 1 cycle after push, count stays 1, no drops or duplicates; pointer wrap exercised.
- Flush priority: queue holding 2 entries, assert flush with f_valid=1 and d_ready=1 same cycle -> next cycle d_valid=0, count=0, pushed instruction absent.
- HALT:
  - Push 16'h0000 then f_valid=1 with 16'hB000 -> halted=1, f_ready=0, HALT reaches decode, B000 never enqueued.
  - flush -> halted=0, f_ready=1.
- Side bands: push f_err=1, f_branch=1 with 16'h6004 -> d_err=1, d_branch=1 only while that entry is head; 0 when empty.

Source files
------------

// File: rtl/if_id_queue_pkg.sv
// -----------------------------------------------------------------------------
// if_id_queue_pkg
// Shared definitions for the fetch->decode instruction queue:
//   - default NOP encoding and HALT opcode
//   - packed queue entry type (34 bits: instr, incPC, err, branch)
//   - queue run/halt state encoding
//   - helper to recognise a HALT opcode
// -----------------------------------------------------------------------------
package if_id_queue_pkg;

    localparam logic [15:0] NOP_INSTR_DEF = 16'h0800;
    localparam logic [4:0]  HALT_OPC_DEF  = 5'b00000;

    typedef struct packed {
        logic [15:0] instr;
        logic [15:0] incPC;
        logic        err;
        logic        branch;
    } if_id_entry_t;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_HALTED = 1'b1
    } q_state_t;

    // Opcode lives in the top five bits of the instruction word.
    function automatic logic is_halt(input logic [15:0] instr, input logic [4:0] opc);
        return (instr[15:11] == opc);
    endfunction

endpackage

// File: rtl/if_id_queue_if.sv
// -----------------------------------------------------------------------------
// if_id_queue_if
// Bundles the fetch-side and decode-side handshakes of the IF/ID queue.
//   master : driven by the environment (fetch + decode + redirect logic)
//   slave  : the queue itself
// Fetch side : f_valid, f_ready, f_instr, f_incPC, f_err, f_branch
// Decode side: d_valid, d_ready, d_instr, d_incPC, d_err, d_branch
// Control    : flush (redirect), halted (intake closed after HALT)
// -----------------------------------------------------------------------------
interface if_id_queue_if;

    logic        f_valid;
    logic        f_ready;
    logic [15:0] f_instr;
    logic [15:0] f_incPC;
    logic        f_err;
    logic        f_branch;
    logic        flush;
    logic        d_valid;
    logic        d_ready;
    logic [15:0] d_instr;
    logic [15:0] d_incPC;
    logic        d_err;
    logic        d_branch;
    logic        halted;

    modport master (
        output f_valid, f_instr, f_incPC, f_err, f_branch, flush, d_ready,
        input  f_ready, d_valid, d_instr, d_incPC, d_err, d_branch, halted
    );

    modport slave (
        input  f_valid, f_instr, f_incPC, f_err, f_branch, flush, d_ready,
        output f_ready, d_valid, d_instr, d_incPC, d_err, d_branch, halted
    );

endinterface

// File: rtl/if_id_queue_store.sv
// -----------------------------------------------------------------------------
// if_id_store
// DEPTH x 34-bit register array holding queued fetch bundles.
//   clk     : clock
//   wr_en   : write wr_data into entry wr_ptr at the rising edge
//   wr_ptr  : write index
//   wr_data : entry to store
//   rd_ptr  : read index
//   rd_data : entry at rd_ptr (combinational read, so the head is visible
//             the cycle after it was written)
// Contents are not reset; the owner tracks occupancy.
// -----------------------------------------------------------------------------
module if_id_store
    import if_id_queue_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_ptr,
    input  if_id_entry_t  wr_data,
    input  logic [AW-1:0] rd_ptr,
    output if_id_entry_t  rd_data
);

    if_id_entry_t entries [DEPTH];

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        if_id_entry_t entry_reg;

        always_ff @(posedge clk) begin
            if (wr_en && (wr_ptr == AW'(gi))) begin
                entry_reg <= wr_data;
            end
        end

        assign entries[gi] = entry_reg;
    end

    assign rd_data = entries[rd_ptr];

endmodule

// File: rtl/if_id_queue.sv
// -----------------------------------------------------------------------------
// if_id_queue
// Registered instruction buffer between fetch and decode. Fetch bundles are
// queued in a small FIFO; the head is presented to decode with valid/ready.
// An empty queue presents NOP_INSTR with zeroed side bands. Enqueuing a HALT
// closes intake until a flush; already queued entries still drain.
//   clk  : clock, all state updates on the rising edge
//   rst  : synchronous active-low reset (0 = reset), priority over flush
//   bus  : if_id_queue_if.slave (fetch handshake, decode handshake, flush,
//          halted)
// f_ready depends only on registered state, never on d_ready, so a full
// queue refuses a push even in a cycle where decode pops.
// -----------------------------------------------------------------------------
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter logic [15:0] NOP_INSTR = NOP_INSTR_DEF,
    parameter logic [4:0]  HALT_OPC  = HALT_OPC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    if_id_queue_if.slave  bus
);

    localparam int             AW         = $clog2(DEPTH);
    localparam int             CW         = AW + 1;
    localparam logic [CW-1:0]  FULL_COUNT = CW'(DEPTH);

    logic [CW-1:0] count_reg,  count_next;
    logic [AW-1:0] wr_ptr_reg, wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg, rd_ptr_next;
    q_state_t      state_reg,  state_next;

    logic          push;
    logic          pop;
    if_id_entry_t  wr_data;
    if_id_entry_t  head;

    assign bus.f_ready = (count_reg != FULL_COUNT) && (state_reg == ST_RUN);
    assign bus.d_valid = (count_reg != '0);
    assign bus.halted  = (state_reg == ST_HALTED);

    assign push = bus.f_valid && bus.f_ready;
    assign pop  = bus.d_valid && bus.d_ready;

    assign wr_data = '{instr:  bus.f_instr,
                       incPC:  bus.f_incPC,
                       err:    bus.f_err,
                       branch: bus.f_branch};

    // A flush cycle must not leave a stray entry behind, so the write is
    // suppressed as well as the pointer update.
    if_id_store #(
        .DEPTH (DEPTH)
    ) u_store (
        .clk     (clk),
        .wr_en   (push && !bus.flush),
        .wr_ptr  (wr_ptr_reg),
        .wr_data (wr_data),
        .rd_ptr  (rd_ptr_reg),
        .rd_data (head)
    );

    assign bus.d_instr  = bus.d_valid ? head.instr  : NOP_INSTR;
    assign bus.d_incPC  = bus.d_valid ? head.incPC  : 16'h0000;
    assign bus.d_err    = bus.d_valid ? head.err    : 1'b0;
    assign bus.d_branch = bus.d_valid ? head.branch : 1'b0;

    // Next-state: flush wins over any same-cycle push/pop.
    always_comb begin
        count_next  = count_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        state_next  = state_reg;

        if (bus.flush) begin
            count_next  = '0;
            wr_ptr_next = '0;
            rd_ptr_next = '0;
            state_next  = ST_RUN;
        end else begin
            if (push) begin
                wr_ptr_next = wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_next = rd_ptr_reg + AW'(1);
            end

            unique case ({push, pop})
                2'b10:   count_next = count_reg + CW'(1);
                2'b01:   count_next = count_reg - CW'(1);
                default: count_next = count_reg;
            endcase

            // push already implies RUN, so only the RUN->HALTED arc exists here.
            unique case (state_reg)
                ST_RUN: begin
                    if (push && is_halt(bus.f_instr, HALT_OPC)) begin
                        state_next = ST_HALTED;
                    end
                end
                ST_HALTED: begin
                    state_next = ST_HALTED;
                end
                default: begin
                    state_next = ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            state_reg  <= ST_RUN;
        end else begin
            count_reg  <= count_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            state_reg  <= state_next;
        end
    end

endmodule

// File: tb/tb_if_id_queue.sv
// -----------------------------------------------------------------------------
// tb_if_id_queue
// Table of per-cycle {inputs, expected outputs} records covering reset,
// fill/drain, streaming, flush priority, HALT and side bands, followed by a
// randomized phase checked against a queue-based reference model.
// Expected output word: {d_valid, d_instr, d_incPC, d_err, d_branch,
//                        f_ready, halted}
// -----------------------------------------------------------------------------
module tb_if_id_queue;
    import if_id_queue_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    if_id_queue_if bus();

    if_id_queue #(
        .DEPTH     (DEPTH),
        .NOP_INSTR (16'h0800),
        .HALT_OPC  (5'b00000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string       name;
        logic        rst_n;
        logic        fv;
        logic [15:0] fi;
        logic [15:0] fp;
        logic        fe;
        logic        fb;
        logic        fl;
        logic        dr;
        logic [36:0] exp;
    } vec_t;

    vec_t          vecs[$];
    int            total = 0;
    int            bad   = 0;

    // reference model state for the random phase
    if_id_entry_t  mq[$];
    bit            mh;
    logic [36:0]   want;
    logic          r_rst, r_fv, r_fe, r_fb, r_fl, r_dr, m_rdy;
    logic [15:0]   r_fi, r_fp;

    function automatic logic [36:0] out(input logic dv, input logic [15:0] di,
                                        input logic [15:0] dp, input logic de,
                                        input logic db, input logic frdy,
                                        input logic hlt);
        return {dv, di, dp, de, db, frdy, hlt};
    endfunction

    function automatic vec_t mk(input string n, input logic r, input logic fv,
                                input logic [15:0] fi, input logic [15:0] fp,
                                input logic fe, input logic fb, input logic fl,
                                input logic dr, input logic [36:0] e);
        vec_t v;
        v.name = n; v.rst_n = r; v.fv = fv; v.fi = fi; v.fp = fp;
        v.fe = fe; v.fb = fb; v.fl = fl; v.dr = dr; v.exp = e;
        return v;
    endfunction

    task automatic drive(input logic r, input logic fv, input logic [15:0] fi,
                         input logic [15:0] fp, input logic fe, input logic fb,
                         input logic fl, input logic dr);
        rst          = r;
        bus.f_valid  = fv;
        bus.f_instr  = fi;
        bus.f_incPC  = fp;
        bus.f_err    = fe;
        bus.f_branch = fb;
        bus.flush    = fl;
        bus.d_ready  = dr;
    endtask

    task automatic check(input string name, input logic [36:0] exp);
        logic [36:0] got;
        got = {bus.d_valid, bus.d_instr, bus.d_incPC, bus.d_err, bus.d_branch,
               bus.f_ready, bus.halted};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got {dv,instr,incPC,err,br,frdy,hlt}=%h required=%h",
                     name, got, exp);
        end else begin
            $display("chk %s dv=%0b instr=%h incPC=%h err=%0b br=%0b frdy=%0b hlt=%0b",
                     name, got[36], got[35:20], got[19:4], got[3], got[2], got[1], got[0]);
        end
    endtask

    logic [36:0] EMPTY;
    logic [36:0] EMPTY_H;

    initial begin
        EMPTY   = out(1'b0, 16'h0800, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
        EMPTY_H = out(1'b0, 16'h0800, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1);

        // reset held two cycles with fetch trying to push
        vecs.push_back(mk("rst_a",    0, 1, 16'h1234, 16'h0002, 0, 0, 0, 1, EMPTY));
        vecs.push_back(mk("rst_b",    0, 1, 16'h1235, 16'h0004, 0, 0, 0, 1, EMPTY));
        vecs.push_back(mk("rst_rel",  1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, EMPTY));
        // fill then drain
        vecs.push_back(mk("fill1",    1, 1, 16'hA001, 16'h0002, 0, 0, 0, 0, out(1, 16'hA001, 16'h0002, 0, 0, 1, 0)));
        vecs.push_back(mk("fill2",    1, 1, 16'hA002, 16'h0004, 0, 0, 0, 0, out(1, 16'hA001, 16'h0002, 0, 0, 0, 0)));
        vecs.push_back(mk("full_rej", 1, 1, 16'hA003, 16'h0006, 0, 0, 0, 0, out(1, 16'hA001, 16'h0002, 0, 0, 0, 0)));
        vecs.push_back(mk("drain1",   1, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, out(1, 16'hA002, 16'h0004, 0, 0, 1, 0)));
        vecs.push_back(mk("drain2",   1, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, EMPTY));
        vecs.push_back(mk("pop_empty",1, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, EMPTY));
        // streaming: each instruction is head exactly one cycle after push
        for (int k = 0; k < 8; k++) begin
            vecs.push_back(mk($sformatf("stream%0d", k), 1, 1, 16'hC001 + 16'(k),
                              16'h0010 + 16'(2 * k), 0, 0, 0, 1,
                              out(1, 16'hC001 + 16'(k), 16'h0010 + 16'(2 * k), 0, 0, 1, 0)));
        end
        vecs.push_back(mk("stream_end", 1, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, EMPTY));
        // flush priority with a full queue
        vecs.push_back(mk("fl_fill1", 1, 1, 16'hD001, 16'h0020, 0, 0, 0, 0, out(1, 16'hD001, 16'h0020, 0, 0, 1, 0)));
        vecs.push_back(mk("fl_fill2", 1, 1, 16'hD002, 16'h0022, 0, 0, 0, 0, out(1, 16'hD001, 16'h0020, 0, 0, 0, 0)));
        vecs.push_back(mk("fl_full",  1, 1, 16'hD003, 16'h0024, 0, 0, 1, 1, EMPTY));
        // flush with room: the same-cycle push must be dropped
        vecs.push_back(mk("fl_one",   1, 1, 16'hD004, 16'h0026, 0, 0, 0, 0, out(1, 16'hD004, 16'h0026, 0, 0, 1, 0)));
        vecs.push_back(mk("fl_push",  1, 1, 16'hD005, 16'h0028, 0, 0, 1, 1, EMPTY));
        vecs.push_back(mk("fl_idle",  1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, EMPTY));
        // HALT closes intake, drains, reopens on flush
        vecs.push_back(mk("halt_push",1, 1, 16'h0000, 16'h0030, 0, 0, 0, 0, out(1, 16'h0000, 16'h0030, 0, 0, 0, 1)));
        vecs.push_back(mk("halt_rej", 1, 1, 16'hB000, 16'h0032, 0, 0, 0, 0, out(1, 16'h0000, 16'h0030, 0, 0, 0, 1)));
        vecs.push_back(mk("halt_pop", 1, 1, 16'hB000, 16'h0032, 0, 0, 0, 1, EMPTY_H));
        vecs.push_back(mk("halt_hold",1, 1, 16'hB000, 16'h0032, 0, 0, 0, 1, EMPTY_H));
        vecs.push_back(mk("halt_fl",  1, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, EMPTY));
        // HALT behind another entry: both drain in order
        vecs.push_back(mk("hq_e001",  1, 1, 16'hE001, 16'h0034, 0, 0, 0, 0, out(1, 16'hE001, 16'h0034, 0, 0, 1, 0)));
        vecs.push_back(mk("hq_halt",  1, 1, 16'h0123, 16'h0036, 0, 0, 0, 0, out(1, 16'hE001, 16'h0034, 0, 0, 0, 1)));
        vecs.push_back(mk("hq_pop1",  1, 1, 16'hB001, 16'h0038, 0, 0, 0, 1, out(1, 16'h0123, 16'h0036, 0, 0, 0, 1)));
        vecs.push_back(mk("hq_pop2",  1, 0, 16'h0000, 16'h0000, 0, 0, 0, 1, EMPTY_H));
        vecs.push_back(mk("hq_fl",    1, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, EMPTY));
        // HALT pushed in a flush cycle is ignored
        vecs.push_back(mk("halt_vs_fl",1, 1, 16'h0000, 16'h003A, 0, 0, 1, 0, EMPTY));
        // side bands follow the head entry only
        vecs.push_back(mk("sb_push",  1, 1, 16'h6004, 16'h0040, 1, 1, 0, 0, out(1, 16'h6004, 16'h0040, 1, 1, 1, 0)));
        vecs.push_back(mk("sb_push2", 1, 1, 16'h7000, 16'h0042, 0, 0, 0, 0, out(1, 16'h6004, 16'h0040, 1, 1, 0, 0)));
        vecs.push_back(mk("sb_pop1",  1, 0, 16'h0000, 16'h0000, 1, 1, 0, 1, out(1, 16'h7000, 16'h0042, 0, 0, 1, 0)));
        vecs.push_back(mk("sb_pop2",  1, 0, 16'h0000, 16'h0000, 1, 1, 0, 1, EMPTY));
        // reset mid-operation, with a simultaneous flush and push
        vecs.push_back(mk("mid_push", 1, 1, 16'h8001, 16'h0050, 0, 0, 0, 0, out(1, 16'h8001, 16'h0050, 0, 0, 1, 0)));
        vecs.push_back(mk("mid_rst",  0, 1, 16'h0000, 16'h0052, 0, 0, 1, 1, EMPTY));
        vecs.push_back(mk("mid_rel",  1, 0, 16'h0000, 16'h0000, 0, 0, 0, 0, EMPTY));

        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].fv, vecs[i].fi, vecs[i].fp,
                  vecs[i].fe, vecs[i].fb, vecs[i].fl, vecs[i].dr);
            @(posedge clk);
            #1;
            check(vecs[i].name, vecs[i].exp);
        end

        // randomized phase; the queue is empty and running here
        mq.delete();
        mh = 1'b0;
        for (int n = 0; n < 400; n++) begin
            r_rst = ($urandom_range(0, 63) != 0);
            r_fv  = ($urandom_range(0, 3) != 0);
            r_fi  = 16'($urandom);
            if ($urandom_range(0, 9) == 0) r_fi[15:11] = 5'b00000;
            else if (r_fi[15:11] == 5'b00000) r_fi[15:11] = 5'b00001;
            r_fp  = 16'($urandom);
            r_fe  = 1'($urandom_range(0, 1));
            r_fb  = 1'($urandom_range(0, 1));
            r_fl  = ($urandom_range(0, 15) == 0);
            r_dr  = ($urandom_range(0, 2) != 0);

            // model: decisions use the pre-edge occupancy and halt flag
            m_rdy = (mq.size() < DEPTH) && !mh;
            if (!r_rst || r_fl) begin
                mq.delete();
                mh = 1'b0;
            end else begin
                if ((mq.size() > 0) && r_dr) void'(mq.pop_front());
                if (r_fv && m_rdy) begin
                    mq.push_back('{instr: r_fi, incPC: r_fp, err: r_fe, branch: r_fb});
                    if (r_fi[15:11] == 5'b00000) mh = 1'b1;
                end
            end

            if (mq.size() > 0)
                want = out(1'b1, mq[0].instr, mq[0].incPC, mq[0].err, mq[0].branch,
                           (mq.size() < DEPTH) && !mh, mh);
            else
                want = out(1'b0, 16'h0800, 16'h0000, 1'b0, 1'b0, !mh, mh);

            drive(r_rst, r_fv, r_fi, r_fp, r_fe, r_fb, r_fl, r_dr);
            @(posedge clk);
            #1;
            check($sformatf("rand%0d", n), want);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
